mdu_issue_ctrl: RTL and testbench
=================================

Name: mdu_issue_ctrl

Overview:
- Initiator side of the multiply/divide unit's start/busy/done handshake.
- Sits between the execute stage and the MDU: accepts one M-extension op and holds the pipeline stalled while the MDU works.
- Issues a single-cycle start, waits for done, selects the architectural result and presents a one-cycle writeback.
- Also handles pipeline flush (drain-and-discard), short-circuits division by zero, and flags a hung MDU via timeout.

Parameters:
- TIMEOUT_CYCLES, 64, maximum cycles in WAIT before the op is abandoned and timeout_err is set.
- DIV0_BYPASS, 1, when 1 the div-by-zero result is produced locally without issuing to the MDU.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- ex_valid  in  1  EX stage holds an M-extension op
- ex_funct3  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- ex_rs1  in  32  operand a
- ex_rs2  in  32  operand b
- ex_rd  in  5  destination register
- flush  in  1  pipeline flush; kills the in-flight op
- stall_o  out  1  holds the EX stage (combinational)
- wb_valid  out  1  one-cycle result strobe
- wb_rd  out  5  destination of result
- wb_data  out  32  result
- mdu_start  out  1  start pulse to the MDU
- mdu_funct3  out  3  latched op
- mdu_a  out  32  latched rs1
- mdu_b  out  32  latched rs2
- mdu_busy  in  1  MDU busy
- mdu_done  in  1  MDU one-cycle done pulse; result buses valid in the same cycle
- mdu_product  in  64  MDU product
- mdu_quotient  in  32  MDU quotient
- mdu_remainder  in  32  MDU remainder
- timeout_err  out  1  sticky error flag

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - mdu_start, wb_valid and timeout_err are 0.
  - wb_rd, wb_data, mdu_funct3, mdu_a and mdu_b are 0.
  - The timeout counter is 0.
  - Reset mid-operation abandons the op silently; the MDU is reset separately.
- States: IDLE, ISSUE, WAIT, DRAIN, WB.
- IDLE:
  - stall_o = ex_valid & ~flush.
  - On ex_valid & ~flush, latch funct3, rs1, rs2 and rd.
  - If DIV0_BYPASS, funct3[2]=1 and rs2==0: wb_data = 0xFFFFFFFF for DIV/DIVU, or the latched rs1 for REM/REMU; next state WB.
  - Otherwise next state ISSUE.
- ISSUE:
  - stall_o = ~flush.
  - mdu_start = 1 only while ~mdu_busy & ~flush; next state WAIT when it fires.
  - flush returns to IDLE with no start issued.
- WAIT:
  - stall_o = ~flush; the timeout counter increments each cycle.
  - On mdu_done, select the result into wb_data, then go to WB:
    - MUL: product[31:0]
    - MULH/MULHSU/MULHU: product[63:32]
    - DIV/DIVU: quotient
    - REM/REMU: remainder
  - If DIV0_BYPASS=0 and the op was REM/REMU with rs2==0, override wb_data with the latched rs1 (the MDU returns |a|).
  - flush without done goes to DRAIN.
  - flush together with done goes to IDLE and the result is discarded.
  - Counter reaching TIMEOUT_CYCLES-1 without done: set timeout_err, go to IDLE, no writeback.
- DRAIN:
  - stall_o = ex_valid & ~flush; no new op is accepted.
  - On mdu_done, go to IDLE and discard the result.
  - The timeout counter still applies in DRAIN.
- WB:
  - wb_valid = ~flush; stall_o = 0, so the pipeline advances.
  - Next state is IDLE unconditionally; the following op is accepted no earlier than the next cycle.
- mdu_start is asserted at most once per accepted op. It is never asserted while mdu_busy=1.
- Timing: wb_valid is asserted in the cycle after mdu_done. With the 32-iteration MDU this is cycle T+36 for an op accepted in cycle T. A bypassed div-by-zero writes back in T+1.
- timeout_err is cleared only by rst.

Test Plan:
- MULHU, rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> exactly one mdu_start; wb_valid at T+36 with wb_data=0xFFFFFFFE; stall_o high T..T+35 and low in the WB cycle.
- MUL 7 x -3 then DIV -7/2 back-to-back -> wb_data 0xFFFFFFEB, then 0xFFFFFFFD; no overlapping starts.
- REM rs1=0x80000005, rs2=0, DIV0_BYPASS=1 -> no mdu_start; wb_valid at T+1 with wb_data=0x80000005. With DIV0_BYPASS=0: issued to the MDU, wb_data still 0x80000005.
- flush 10 cycles into WAIT -> state DRAIN, stall_o follows ex_valid, mdu_done discarded (no wb_valid), next op issues after the drain.
- Stub MDU that never asserts done, TIMEOUT_CYCLES=64 -> timeout_err=1 after 64 WAIT cycles, stall released, no writeback; flag stays set until rst.
- Assert rst during WAIT -> all outputs 0 immediately (async); a subsequent op completes normally.

Source files
------------

// File: rtl/mdu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// mdu_issue_ctrl_if : start/busy/done handshake bundle between issue ctrl & MDU
// Revision: 1.0
// ============================================================================
interface mdu_issue_ctrl_if;
  logic        mdu_start;
  logic [2:0]  mdu_funct3;
  logic [31:0] mdu_a;
  logic [31:0] mdu_b;
  logic        mdu_busy;
  logic        mdu_done;
  logic [63:0] mdu_product;
  logic [31:0] mdu_quotient;
  logic [31:0] mdu_remainder;

  modport master (
    output mdu_start, mdu_funct3, mdu_a, mdu_b,
    input  mdu_busy, mdu_done, mdu_product, mdu_quotient, mdu_remainder
  );

  modport slave (
    input  mdu_start, mdu_funct3, mdu_a, mdu_b,
    output mdu_busy, mdu_done, mdu_product, mdu_quotient, mdu_remainder
  );
endinterface
`default_nettype wire

// File: rtl/mdu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// mdu_issue_ctrl : issues one M-extension op to the MDU, stalls EX, writes back
// Revision: 1.0
// ============================================================================
module mdu_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter bit DIV0_BYPASS    = 1'b1
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        ex_valid,
  input  wire logic [2:0]  ex_funct3,
  input  wire logic [31:0] ex_rs1,
  input  wire logic [31:0] ex_rs2,
  input  wire logic [4:0]  ex_rd,
  input  wire logic        flush,
  output logic             stall_o,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [31:0]      wb_data,
  mdu_issue_ctrl_if.master mdu,
  output logic             timeout_err
);

  localparam int              CNT_W        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_WB    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [4:0]       rd_q, rd_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic             start_w;
  logic [31:0]      result_w;

  always_comb begin
    result_w = mdu.mdu_remainder;
    case (funct3_q)
      3'd0:             result_w = mdu.mdu_product[31:0];
      3'd1, 3'd2, 3'd3: result_w = mdu.mdu_product[63:32];
      3'd4, 3'd5:       result_w = mdu.mdu_quotient;
      default:          result_w = mdu.mdu_remainder;
    endcase
    // The MDU returns |a| for REM by zero; the architectural result is a itself.
    if (!DIV0_BYPASS && funct3_q[2] && funct3_q[1] && (b_q == 32'd0)) begin
      result_w = a_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    funct3_d      = funct3_q;
    a_d           = a_q;
    b_d           = b_q;
    rd_d          = rd_q;
    wb_data_d     = wb_data_q;
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
    stall_o       = 1'b0;
    wb_valid      = 1'b0;
    start_w       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        stall_o = ex_valid & ~flush;
        if (ex_valid && !flush) begin
          funct3_d = ex_funct3;
          a_d      = ex_rs1;
          b_d      = ex_rs2;
          rd_d     = ex_rd;
          if (DIV0_BYPASS && ex_funct3[2] && (ex_rs2 == 32'd0)) begin
            wb_data_d = ex_funct3[1] ? ex_rs1 : 32'hFFFF_FFFF;
            state_d   = ST_WB;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        stall_o = ~flush;
        cnt_d   = '0;
        if (flush) begin
          state_d = ST_IDLE;
        end else if (!mdu.mdu_busy) begin
          start_w = 1'b1;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        stall_o = ~flush;
        cnt_d   = cnt_q + CNT_W'(1);
        if (mdu.mdu_done) begin
          if (flush) begin
            state_d = ST_IDLE;
          end else begin
            wb_data_d = result_w;
            state_d   = ST_WB;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        // A killed op must still see its done before the MDU can be reused.
        stall_o = ex_valid & ~flush;
        cnt_d   = cnt_q + CNT_W'(1);
        if (mdu.mdu_done) begin
          state_d = ST_IDLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end

      ST_WB: begin
        wb_valid = ~flush;
        state_d  = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      funct3_q      <= 3'd0;
      a_q           <= 32'd0;
      b_q           <= 32'd0;
      rd_q          <= 5'd0;
      wb_data_q     <= 32'd0;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      funct3_q      <= funct3_d;
      a_q           <= a_d;
      b_q           <= b_d;
      rd_q          <= rd_d;
      wb_data_q     <= wb_data_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign mdu.mdu_start  = start_w;
  assign mdu.mdu_funct3 = funct3_q;
  assign mdu.mdu_a      = a_q;
  assign mdu.mdu_b      = b_q;
  assign wb_rd          = rd_q;
  assign wb_data        = wb_data_q;
  assign timeout_err    = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mdu_issue_ctrl : directed bench for mdu_issue_ctrl with a 32-iteration MDU model
// Revision: 1.0
// ============================================================================
module tb_mdu_issue_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        ex_valid, ex_valid1, flush;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1, ex_rs2;
  logic [4:0]  ex_rd;

  logic        stall_o, wb_valid, timeout_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall_o1, wb_valid1, timeout_err1;
  logic [4:0]  wb_rd1;
  logic [31:0] wb_data1;

  mdu_issue_ctrl_if if0 ();
  mdu_issue_ctrl_if if1 ();

  mdu_issue_ctrl #(.TIMEOUT_CYCLES(64), .DIV0_BYPASS(1'b1)) dut0 (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_funct3(ex_funct3),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .flush(flush),
    .stall_o(stall_o), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .mdu(if0), .timeout_err(timeout_err)
  );

  mdu_issue_ctrl #(.TIMEOUT_CYCLES(64), .DIV0_BYPASS(1'b0)) dut1 (
    .clk(clk), .rst(rst), .ex_valid(ex_valid1), .ex_funct3(ex_funct3),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .flush(flush),
    .stall_o(stall_o1), .wb_valid(wb_valid1), .wb_rd(wb_rd1), .wb_data(wb_data1),
    .mdu(if1), .timeout_err(timeout_err1)
  );

  // MDU model: done in the 34th cycle after the start cycle
  logic        never_done = 1'b0;
  int          starts = 0, overlap = 0, starts1 = 0;
  int unsigned lat_cnt;
  logic [63:0] m_prod;
  logic [31:0] m_quo, m_rem;

  function automatic logic [63:0] f_prod(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    logic [63:0] ea, eb;
    ea = (f == 3'd3) ? {32'd0, a} : {{32{a[31]}}, a};
    eb = (f <= 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  function automatic logic [31:0] f_quo(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    if (b == 32'd0) return 32'hFFFF_FFFF;
    if (!f[0]) return $signed(a) / $signed(b);
    return a / b;
  endfunction

  function automatic logic [31:0] f_rem(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    if (b == 32'd0) return (!f[0] && a[31]) ? (32'd0 - a) : a;
    if (!f[0]) return $signed(a) % $signed(b);
    return a % b;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      if0.mdu_busy <= 1'b0;
      lat_cnt      <= 0;
    end else if (if0.mdu_start) begin
      if (if0.mdu_busy) overlap <= overlap + 1;
      starts       <= starts + 1;
      if0.mdu_busy <= 1'b1;
      lat_cnt      <= 0;
      m_prod       <= f_prod(if0.mdu_funct3, if0.mdu_a, if0.mdu_b);
      m_quo        <= f_quo(if0.mdu_funct3, if0.mdu_a, if0.mdu_b);
      m_rem        <= f_rem(if0.mdu_funct3, if0.mdu_a, if0.mdu_b);
    end else if (if0.mdu_busy) begin
      lat_cnt <= lat_cnt + 1;
      if (lat_cnt == 33 && !never_done) if0.mdu_busy <= 1'b0;
    end
  end

  assign if0.mdu_done      = if0.mdu_busy && (lat_cnt == 33) && !never_done;
  assign if0.mdu_product   = m_prod;
  assign if0.mdu_quotient  = m_quo;
  assign if0.mdu_remainder = m_rem;

  always @(posedge clk) if (if1.mdu_start) starts1 <= starts1 + 1;

  int vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one op in the next cycle and follows it to its writeback cycle.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_data, input int exp_lat, input int exp_starts);
    int n, s0;
    bit stall_ok;
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_funct3 = f; ex_rs1 = a; ex_rs2 = b; ex_rd = rd;
    #1;
    s0 = starts; stall_ok = 1'b1; n = 0;
    while (n <= 100) begin
      if (wb_valid === 1'b1) break;
      if (stall_o !== 1'b1) stall_ok = 1'b0;
      @(posedge clk); #2;
      n++;
    end
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_data"}, wb_data, exp_data);
    chk({tag, "_rd"}, wb_rd, rd);
    chk({tag, "_wb_stall"}, stall_o, 1'b0);
    chk({tag, "_stall_held"}, stall_ok, 1'b1);
    chk({tag, "_starts"}, starts - s0, exp_starts);
  endtask

  task automatic idle();
    @(posedge clk); #1; ex_valid = 1'b0; #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int  s0, n;
    bit  bad;
    rst = 1'b1; ex_valid = 1'b0; ex_valid1 = 1'b0; flush = 1'b0;
    ex_funct3 = 3'd0; ex_rs1 = 32'd0; ex_rs2 = 32'd0; ex_rd = 5'd0;
    if1.mdu_busy = 1'b0; if1.mdu_done = 1'b0; if1.mdu_product = 64'd0;
    if1.mdu_quotient = 32'd0; if1.mdu_remainder = 32'd0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_timeout", timeout_err, 1'b0);
    chk("rst_start", if0.mdu_start, 1'b0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_mdu_a", if0.mdu_a, 32'd0);
    chk("rst_stall", stall_o, 1'b0);
    @(negedge clk) rst = 1'b0;

    run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 36, 1);
    run_op("mul",    3'd0, 32'd7,         32'hFFFF_FFFD, 5'd4, 32'hFFFF_FFEB, 36, 1);
    run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2,         5'd5, 32'hFFFF_FFFD, 36, 1);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2,         5'd6, 32'hFFFF_FFFF, 36, 1);
    run_op("remu",   3'd7, 32'd100,       32'd7,         5'd7, 32'd2,         36, 1);
    run_op("rem_z",  3'd6, 32'h8000_0005, 32'd0,         5'd8, 32'h8000_0005, 1,  0);
    run_op("divu_z", 3'd5, 32'h0000_1234, 32'd0,         5'd9, 32'hFFFF_FFFF, 1,  0);
    idle();
    chk("no_overlap", overlap, 0);

    // flush while in ISSUE: no start may escape
    s0 = starts;
    @(posedge clk); #1; ex_valid = 1'b1; ex_funct3 = 3'd0; ex_rs1 = 32'd2; ex_rs2 = 32'd3; #1;
    @(posedge clk); #1; flush = 1'b1; #1;
    chk("iss_flush_start", if0.mdu_start, 1'b0);
    chk("iss_flush_stall", stall_o, 1'b0);
    @(posedge clk); #1; flush = 1'b0; ex_valid = 1'b0; #1;
    repeat (3) @(posedge clk);
    #2;
    chk("iss_flush_starts", starts - s0, 0);

    // flush 10 cycles into WAIT
    s0 = starts;
    @(posedge clk); #1; ex_valid = 1'b1; ex_funct3 = 3'd4; ex_rs1 = 32'd100; ex_rs2 = 32'd7; ex_rd = 5'd9; #1;
    repeat (11) @(posedge clk);
    #1; flush = 1'b1; #1;
    chk("wflush_stall", stall_o, 1'b0);
    @(posedge clk); #1; flush = 1'b0; ex_valid = 1'b0; #1;
    chk("drain_stall_lo", stall_o, 1'b0);
    ex_valid = 1'b1; #1;
    chk("drain_stall_hi", stall_o, 1'b1);
    @(posedge clk); #1; ex_valid = 1'b0; #1;
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (wb_valid !== 1'b0 || if0.mdu_start !== 1'b0) bad = 1'b1;
      @(posedge clk); #2;
    end
    chk("drain_discard", bad, 1'b0);
    chk("drain_starts", starts - s0, 1);
    run_op("post_drain", 3'd0, 32'd3, 32'd5, 5'd10, 32'd15, 36, 1);
    idle();

    // hung MDU
    never_done = 1'b1; s0 = starts; bad = 1'b0; n = 0;
    @(posedge clk); #1; ex_valid = 1'b1; ex_funct3 = 3'd0; ex_rs1 = 32'd1; ex_rs2 = 32'd1; ex_rd = 5'd11; #1;
    while (timeout_err !== 1'b1 && n < 200) begin
      if (wb_valid === 1'b1) bad = 1'b1;
      @(posedge clk); #2;
      n++;
    end
    ex_valid = 1'b0; #1;
    chk("to_cycle", n, 66);
    chk("to_no_wb", bad, 1'b0);
    chk("to_stall_rel", stall_o, 1'b0);
    chk("to_starts", starts - s0, 1);
    repeat (5) @(posedge clk);
    #2;
    chk("to_sticky", timeout_err, 1'b1);

    never_done = 1'b0;
    @(posedge clk); #3; rst = 1'b1; #1;
    chk("to_rst_clear", timeout_err, 1'b0);
    @(negedge clk) rst = 1'b0;

    // async reset in WAIT
    @(posedge clk); #1; ex_valid = 1'b1; ex_funct3 = 3'd1; ex_rs1 = 32'h1234_5678; ex_rs2 = 32'h9; ex_rd = 5'd12; #1;
    repeat (10) @(posedge clk);
    #3; rst = 1'b1; ex_valid = 1'b0; #1;
    chk("arst_stall", stall_o, 1'b0);
    chk("arst_start", if0.mdu_start, 1'b0);
    chk("arst_a", if0.mdu_a, 32'd0);
    chk("arst_b", if0.mdu_b, 32'd0);
    chk("arst_funct3", if0.mdu_funct3, 3'd0);
    chk("arst_wb_data", wb_data, 32'd0);
    chk("arst_wb_rd", wb_rd, 5'd0);
    @(negedge clk) rst = 1'b0;
    run_op("post_rst", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd12, 32'h4000_0000, 36, 1);
    idle();

    // no bypass: REM by zero goes to the MDU, result still rs1
    @(posedge clk); #1;
    ex_valid1 = 1'b1; ex_funct3 = 3'd6; ex_rs1 = 32'h8000_0005; ex_rs2 = 32'd0; ex_rd = 5'd13; #1;
    chk("nb_accept_stall", stall_o1, 1'b1);
    @(posedge clk); #2;
    chk("nb_start", if1.mdu_start, 1'b1);
    @(posedge clk); #1; if1.mdu_busy = 1'b1; #1;
    chk("nb_wait_stall", stall_o1, 1'b1);
    @(posedge clk); #1;
    if1.mdu_done = 1'b1; if1.mdu_remainder = 32'h7FFF_FFFB; if1.mdu_quotient = 32'hFFFF_FFFF; #1;
    @(posedge clk); #1; if1.mdu_done = 1'b0; if1.mdu_busy = 1'b0; ex_valid1 = 1'b0; #1;
    chk("nb_wb_valid", wb_valid1, 1'b1);
    chk("nb_wb_data", wb_data1, 32'h8000_0005);
    chk("nb_starts", starts1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
